paint_canvas_buffer: RTL and testbench

Multi-brush paint canvas frame buffer, the parametrised successor of the two-brush frame buffer. It sits between the brush trackers and the video output stage. It scans the raster position, paints any pixel inside up to NUM_BRUSH circular brushes into an on-chip colour-index RAM, and outputs palette-decoded RGB for the same raster stream. Adds a hardware clear-screen sweeper, per-brush enables, fixed-priority brush arbitration and a pipelined distance test.

---
 rtl/paint_canvas_buffer.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_paint_canvas_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/paint_canvas_buffer.sv
// paint_canvas_buffer: multi-brush paint canvas frame buffer.
// Scans the raster, paints pixels covered by up to NUM_BRUSH circular brushes into a
// colour-index RAM and emits palette-decoded RGB 3 cycles after each raster position.
// A clear sweeper overwrites the whole canvas with BG_COLOR on request.
// Optional macro SQUARE_BRUSH_EN: square hit test (|dx|<=r && |dy|<=r) instead of a circle.
module paint_canvas_buffer #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 360,
  parameter int unsigned NUM_BRUSH = 2,
  parameter int unsigned COLOR_W   = 4,
  parameter int unsigned SIZE_W    = 3,
  parameter int unsigned BG_COLOR  = 0,
  localparam int unsigned X_W = $clog2(H_ACTIVE),
  localparam int unsigned Y_W = $clog2(V_ACTIVE)
) (
  input  logic                           pixel_clk_in,
  input  logic                           rst_in,
  input  logic [X_W-1:0]                 hcount_in,
  input  logic [Y_W-1:0]                 vcount_in,
  input  logic [NUM_BRUSH-1:0]           brush_en_in,
  input  logic [NUM_BRUSH*X_W-1:0]       x_in,
  input  logic [NUM_BRUSH*Y_W-1:0]       y_in,
  input  logic [NUM_BRUSH*COLOR_W-1:0]   color_in,
  input  logic [NUM_BRUSH*SIZE_W-1:0]    size_in,
  input  logic                           clear_in,
  output logic                           clear_busy_out,
  output logic [7:0]                     red_out,
  output logic [7:0]                     green_out,
  output logic [7:0]                     blue_out
);

  localparam int unsigned DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned MW    = (X_W > Y_W) ? X_W : Y_W;
  localparam int unsigned RW    = SIZE_W + 1;
`ifdef SQUARE_BRUSH_EN
  // Magnitudes of dx/dy and the radius share one compare width.
  localparam int unsigned GW = ((MW + 1) > RW) ? (MW + 1) : RW;
`else
  // Sum of two squares of (MW+1)-bit signed deltas, or r squared, whichever is wider.
  localparam int unsigned GW = ((2 * MW + 2) > (2 * RW)) ? (2 * MW + 2) : (2 * RW);
`endif

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [23:0] palette(input logic [COLOR_W-1:0] idx);
    logic [23:0] rgb;
    case (int'(idx))
      0:       rgb = 24'h000000;
      1:       rgb = 24'hFFFFFF;
      2:       rgb = 24'hFF0000;
      3:       rgb = 24'h00FF00;
      4:       rgb = 24'h0000FF;
      5:       rgb = 24'h00FFFF;
      6:       rgb = 24'hFF00FF;
      7:       rgb = 24'hFFFF00;
      8:       rgb = 24'h808080;
      default: rgb = 24'hFFFFFF;
    endcase
    return rgb;
  endfunction

  // Raster decode
  logic [31:0]            w_addr_wide;
  logic                   w_in_range;
  logic [AW-1:0]          w_addr;
  logic signed [X_W:0]    w_dx [NUM_BRUSH];
  logic signed [Y_W:0]    w_dy [NUM_BRUSH];

  // S0
  logic                   r_s0_valid;
  logic [AW-1:0]          r_s0_addr;
  logic [NUM_BRUSH-1:0]   r_s0_en;
  logic signed [X_W:0]    r_s0_dx [NUM_BRUSH];
  logic signed [Y_W:0]    r_s0_dy [NUM_BRUSH];
  logic [COLOR_W-1:0]     r_s0_color [NUM_BRUSH];
  logic [SIZE_W-1:0]      r_s0_size [NUM_BRUSH];

  // S1
  logic [GW-1:0]          w_ga [NUM_BRUSH];
  logic [GW-1:0]          w_gr [NUM_BRUSH];
  logic [GW-1:0]          r_s1_ga [NUM_BRUSH];
  logic [GW-1:0]          r_s1_gr [NUM_BRUSH];
`ifdef SQUARE_BRUSH_EN
  logic [GW-1:0]          w_gb [NUM_BRUSH];
  logic [GW-1:0]          r_s1_gb [NUM_BRUSH];
`endif
  logic [AW-1:0]          r_s1_addr;
  logic [NUM_BRUSH-1:0]   r_s1_en;
  logic [COLOR_W-1:0]     r_s1_color [NUM_BRUSH];

  // S2 / write port
  logic [NUM_BRUSH-1:0]   w_hit;
  logic                   w_any_hit;
  logic [COLOR_W-1:0]     w_hit_color;
  logic                   w_we;
  logic [AW-1:0]          w_waddr;
  logic [COLOR_W-1:0]     w_wdata;

  // Memory and read path
  logic [COLOR_W-1:0]     r_mem [DEPTH];
  logic [COLOR_W-1:0]     r_rd_data;
  logic                   r_rd_valid;
  logic [23:0]            r_rgb;

  // Clear FSM
  state_e                 r_state;
  state_e                 w_state_next;
  logic [AW-1:0]          r_clr_cnt;
  logic                   w_clr_last;
  logic                   w_clr_we;

  // Raster address, range flag and per-brush signed deltas
  always_comb begin
    w_addr_wide = 32'(hcount_in) + H_ACTIVE * 32'(vcount_in);
    w_in_range  = (32'(hcount_in) < H_ACTIVE) && (32'(vcount_in) < V_ACTIVE);
    // Out-of-range positions read address 0; their output is forced black later.
    w_addr      = w_in_range ? AW'(w_addr_wide) : '0;
    for (int i = 0; i < int'(NUM_BRUSH); i++) begin
      w_dx[i] = $signed({1'b0, hcount_in}) - $signed({1'b0, x_in[i*X_W +: X_W]});
      w_dy[i] = $signed({1'b0, vcount_in}) - $signed({1'b0, y_in[i*Y_W +: Y_W]});
    end
  end

  // S0: register address, range flag and per-brush deltas/attributes
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s0_valid <= 1'b0;
      r_s0_addr  <= '0;
      r_s0_en    <= '0;
      for (int i = 0; i < int'(NUM_BRUSH); i++) begin
        r_s0_dx[i]    <= '0;
        r_s0_dy[i]    <= '0;
        r_s0_color[i] <= '0;
        r_s0_size[i]  <= '0;
      end
    end else begin
      r_s0_valid <= w_in_range;
      r_s0_addr  <= w_addr;
      r_s0_en    <= brush_en_in;
      for (int i = 0; i < int'(NUM_BRUSH); i++) begin
        r_s0_dx[i]    <= w_dx[i];
        r_s0_dy[i]    <= w_dy[i];
        r_s0_color[i] <= color_in[i*COLOR_W +: COLOR_W];
        r_s0_size[i]  <= size_in[i*SIZE_W +: SIZE_W];
      end
    end
  end

  // S1 geometry: squared distance and squared radius (or magnitudes for square brushes)
  always_comb begin
    for (int i = 0; i < int'(NUM_BRUSH); i++) begin
`ifdef SQUARE_BRUSH_EN
      w_ga[i] = GW'(iabs(int'(r_s0_dx[i])));
      w_gb[i] = GW'(iabs(int'(r_s0_dy[i])));
      w_gr[i] = GW'(int'({r_s0_size[i], 1'b1}));
`else
      w_ga[i] = GW'(int'(r_s0_dx[i]) * int'(r_s0_dx[i]) +
                    int'(r_s0_dy[i]) * int'(r_s0_dy[i]));
      w_gr[i] = GW'(int'({r_s0_size[i], 1'b1}) * int'({r_s0_size[i], 1'b1}));
`endif
    end
  end

  // S1: register geometry results; fold the range flag into the brush enables
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s1_addr <= '0;
      r_s1_en   <= '0;
      for (int i = 0; i < int'(NUM_BRUSH); i++) begin
        r_s1_ga[i]    <= '0;
        r_s1_gr[i]    <= '0;
`ifdef SQUARE_BRUSH_EN
        r_s1_gb[i]    <= '0;
`endif
        r_s1_color[i] <= '0;
      end
    end else begin
      r_s1_addr <= r_s0_addr;
      r_s1_en   <= r_s0_en & {NUM_BRUSH{r_s0_valid}};
      for (int i = 0; i < int'(NUM_BRUSH); i++) begin
        r_s1_ga[i]    <= w_ga[i];
        r_s1_gr[i]    <= w_gr[i];
`ifdef SQUARE_BRUSH_EN
        r_s1_gb[i]    <= w_gb[i];
`endif
        r_s1_color[i] <= r_s0_color[i];
      end
    end
  end

  // S2: hit test and fixed priority, lowest index wins
  always_comb begin
    w_hit       = '0;
    w_any_hit   = 1'b0;
    w_hit_color = '0;
    for (int i = 0; i < int'(NUM_BRUSH); i++) begin
`ifdef SQUARE_BRUSH_EN
      w_hit[i] = r_s1_en[i] && (r_s1_ga[i] <= r_s1_gr[i]) && (r_s1_gb[i] <= r_s1_gr[i]);
`else
      w_hit[i] = r_s1_en[i] && (r_s1_gr[i] >= r_s1_ga[i]);
`endif
    end
    for (int i = int'(NUM_BRUSH) - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any_hit   = 1'b1;
        w_hit_color = r_s1_color[i];
      end
    end
  end

  // Write port mux: the clear sweep owns the port and blocks brush writes
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_s1_addr;
    w_wdata = w_hit_color;
    if (w_clr_we) begin
      w_we    = 1'b1;
      w_waddr = r_clr_cnt;
      w_wdata = COLOR_W'(BG_COLOR);
    end else if (w_any_hit) begin
      w_we    = 1'b1;
    end
  end

  // Canvas RAM: one write port, registered read-first read port
  always_ff @(posedge pixel_clk_in) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    r_rd_data <= r_mem[r_s0_addr];
  end

  // Read-path valid and registered palette decode
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rd_valid <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_rd_valid <= r_s0_valid;
      r_rgb      <= r_rd_valid ? palette(r_rd_data) : 24'h000000;
    end
  end

  assign {red_out, green_out, blue_out} = r_rgb;

  // Clear FSM state register
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sweep counter: held at 0 while idle, advances once per clearing cycle
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_clr_cnt <= '0;
    end else if (r_state == StClear) begin
      r_clr_cnt <= r_clr_cnt + AW'(1);
    end else begin
      r_clr_cnt <= '0;
    end
  end

  assign w_clr_last = (r_clr_cnt == AW'(DEPTH - 1));

  // Clear FSM next state; requests during a sweep are ignored
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (clear_in) w_state_next = StClear;
      StClear: if (w_clr_last) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Clear FSM outputs
  always_comb begin
    clear_busy_out = 1'b0;
    w_clr_we       = 1'b0;
    if (r_state == StClear) begin
      clear_busy_out = 1'b1;
      w_clr_we       = 1'b1;
    end
  end

endmodule

// File: tb/tb_paint_canvas_buffer.sv
// tb_paint_canvas_buffer: directed bench for paint_canvas_buffer on a reduced 40x20 canvas.
module tb_paint_canvas_buffer;

  localparam int unsigned H  = 40;
  localparam int unsigned V  = 20;
  localparam int unsigned NB = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 3;
  localparam int unsigned XW = $clog2(H);
  localparam int unsigned YW = $clog2(V);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [XW-1:0]     hcount;
  logic [YW-1:0]     vcount;
  logic [NB-1:0]     brush_en;
  logic [NB*XW-1:0]  bx;
  logic [NB*YW-1:0]  by;
  logic [NB*CW-1:0]  bcol;
  logic [NB*SW-1:0]  bsize;
  logic              clear;
  logic              busy;
  logic [7:0]        red, green, blue;
  logic [23:0]       rgb;

  int n_cmp  = 0;
  int n_fail = 0;
  int n;
  int nz;

  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  paint_canvas_buffer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .NUM_BRUSH(NB),
    .COLOR_W  (CW),
    .SIZE_W   (SW),
    .BG_COLOR (0)
  ) dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst_n),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .brush_en_in   (brush_en),
    .x_in          (bx),
    .y_in          (by),
    .color_in      (bcol),
    .size_in       (bsize),
    .clear_in      (clear),
    .clear_busy_out(busy),
    .red_out       (red),
    .green_out     (green),
    .blue_out      (blue)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_brush(input int i, input bit en, input int x, input int y,
                           input int col, input int sz);
    brush_en[i]          = en;
    bx[i*XW +: XW]       = XW'(x);
    by[i*YW +: YW]       = YW'(y);
    bcol[i*CW +: CW]     = CW'(col);
    bsize[i*SW +: SW]    = SW'(sz);
  endtask

  // One full raster pass; counts non-black output samples, then flushes the pipeline.
  task automatic frame(output int nonzero);
    nonzero = 0;
    for (int v = 0; v < int'(V); v++) begin
      for (int h = 0; h < int'(H); h++) begin
        hcount = XW'(h);
        vcount = YW'(v);
        tick();
        if (rgb !== 24'h0) nonzero++;
      end
    end
    hcount = '1;
    vcount = '0;
    repeat (4) tick();
  endtask

  task automatic probe(input string tag, input int h, input int v, input logic [23:0] exp);
    hcount = XW'(h);
    vcount = YW'(v);
    repeat (3) tick();
    check(tag, 32'(rgb), 32'(exp));
  endtask

  // Pulses clear; returns the number of cycles busy stayed high. A second request is
  // issued after `again` busy cycles when again > 0.
  task automatic sweep(input int again, output int cycles);
    hcount = '1;
    vcount = '0;
    clear  = 1'b1;
    tick();
    clear  = 1'b0;
    cycles = 0;
    while (busy && cycles < 2000) begin
      cycles++;
      clear = (again > 0 && cycles == again);
      tick();
    end
    clear = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    hcount   = '0;
    vcount   = '0;
    brush_en = '0;
    bx       = '0;
    by       = '0;
    bcol     = '0;
    bsize    = '0;
    clear    = 1'b0;
    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rgb", 32'(rgb), 32'h0);
    rst_n = 1'b1;
    tick();

    // Initial sweep gives a known canvas and measures the sweep length.
    sweep(0, n);
    check("clear_len", n, H * V);
    check("clear_done_busy", 32'(busy), 32'h0);

    // Blank canvas, no brushes.
    frame(nz);
    check("blank_frame_nonzero", nz, 0);
    check("blank_busy", 32'(busy), 32'h0);

    // Single brush, r=1, red.
    set_brush(0, 1'b1, 10, 5, 2, 0);
    frame(nz);
    set_brush(0, 1'b0, 10, 5, 2, 0);
    probe("b0_center", 10, 5, 24'hFF0000);
    probe("b0_right", 11, 5, 24'hFF0000);
    probe("b0_up", 10, 4, 24'hFF0000);
    probe("b0_x+2", 12, 5, 24'h000000);
    probe("b0_y+1", 10, 6, 24'hFF0000);
`ifdef SQUARE_BRUSH_EN
    probe("b0_diag", 11, 6, 24'hFF0000);
`else
    probe("b0_diag", 11, 6, 24'h000000);
`endif

    // Exact 3-cycle latency: one red pixel between black ones.
    hcount = XW'(12);
    vcount = YW'(5);
    repeat (4) tick();
    check("lat_pre", 32'(rgb), 32'h0);
    hcount = XW'(10);
    tick();
    hcount = XW'(12);
    tick();
    check("lat_2cyc", 32'(rgb), 32'h0);
    tick();
    check("lat_3cyc", 32'(rgb), 32'hFF0000);
    tick();
    check("lat_4cyc", 32'(rgb), 32'h0);

    // Overlapping brushes: brush0 green wins over brush1 blue; then brush1 alone.
    set_brush(0, 1'b1, 20, 10, 3, 1);
    set_brush(1, 1'b1, 20, 10, 4, 1);
    frame(nz);
    set_brush(0, 1'b0, 20, 10, 3, 1);
    set_brush(1, 1'b1, 30, 10, 4, 1);
    frame(nz);
    set_brush(1, 1'b0, 30, 10, 4, 1);
    probe("ovl_center", 20, 10, 24'h00FF00);
    probe("ovl_edge", 22, 11, 24'h00FF00);
    probe("b1_center", 30, 10, 24'h0000FF);
    probe("b1_r_eq", 33, 10, 24'h0000FF);
    probe("b1_outside", 34, 10, 24'h000000);

    // Corner brush r=5, yellow: clipped, no wrap-around.
    set_brush(0, 1'b1, 0, 0, 7, 2);
    frame(nz);
    set_brush(0, 1'b0, 0, 0, 7, 2);
    probe("corner_0_0", 0, 0, 24'hFFFF00);
    probe("corner_5_0", 5, 0, 24'hFFFF00);
    probe("corner_6_0", 6, 0, 24'h000000);
    probe("corner_0_5", 0, 5, 24'hFFFF00);
    probe("wrap_x", 39, 0, 24'h000000);
    probe("wrap_xy", 39, 19, 24'h000000);
    probe("oor_h40", 40, 0, 24'h000000);
    probe("oor_v20", 0, 20, 24'h000000);

    // Clear with a repeated request mid-sweep; busy length must not change.
    sweep(100, n);
    check("clear2_len", n, H * V);
    frame(nz);
    check("cleared_frame_nonzero", nz, 0);

    // Reset in the middle of a sweep drops busy immediately.
    hcount = '1;
    clear  = 1'b1;
    tick();
    clear  = 1'b0;
    repeat (50) tick();
    check("mid_sweep_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_rgb", 32'(rgb), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
